// File: rtl/agc_sequencer.sv
// agc_sequencer: AGC control unit; fetches, increments Z through the ALU, then runs per-opcode micro-cycles.
// Ports: clk, reset_n (async active-low), mem_data/acc_zero from the datapath; alu_op, mux selects,
//        write enables, instr_done pulse and latched opcode drive the datapath.
// Optional: define AGC_SEQ_STEP_EN to add the step input and a HOLD state between instructions.
module agc_sequencer #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef AGC_SEQ_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] mem_data,
    input  logic        acc_zero,
    output logic [2:0]  alu_op,
    output logic [1:0]  MAddr_MUX,
    output logic [1:0]  Q_MUX,
    output logic [1:0]  A_MUX,
    output logic [1:0]  X_MUX,
    output logic [1:0]  Z_MUX,
    output logic [1:0]  Y_MUX,
    output logic        LP_MUX,
    output logic        B_MUX,
    output logic        LP_WE,
    output logic        G_WE,
    output logic        Q_WE,
    output logic        B_WE,
    output logic        A_WE,
    output logic        Y_WE,
    output logic        X_WE,
    output logic        Z_WE,
    output logic        mem_WE,
    output logic        instr_done,
    output logic [2:0]  opcode
);
    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_INC_LD = 4'd2, S_WAIT = 4'd3, S_INC_WB = 4'd4;
    localparam logic [3:0] S_EX1 = 4'd5, S_EX2 = 4'd6, S_EX3 = 4'd7, S_HOLD = 4'd8;
`ifdef AGC_SEQ_STEP_EN
    localparam logic [3:0] S_DONE = S_HOLD;
`else
    localparam logic [3:0] S_DONE = S_FETCH;
`endif
    localparam logic [2:0] OP_TC = 3'd0, OP_CA = 3'd1, OP_AD = 3'd2, OP_MASK = 3'd3;
    localparam logic [2:0] OP_TS = 3'd4, OP_XCH = 3'd5, OP_CS = 3'd6;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_AND = 3'd2;
    localparam logic [1:0] LAT_M1 = (ALU_LAT > 0) ? 2'(ALU_LAT - 1) : 2'd0;

    logic [3:0] r_state, w_next;
    logic [2:0] r_opcode;
    logic [1:0] r_cnt;
    logic       r_ret;
    logic       w_adm;
    logic [2:0] w_alu;
    logic       w_unused;

    assign w_unused = ^mem_data[12:0];
    assign w_adm    = (r_opcode == OP_AD) || (r_opcode == OP_MASK);
    assign w_alu    = (r_opcode == OP_MASK) ? ALU_AND : ALU_ADD;
    assign opcode   = r_opcode;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_RST:    w_next = S_FETCH;
            S_FETCH:  w_next = S_INC_LD;
            S_INC_LD: w_next = (ALU_LAT == 0) ? S_INC_WB : S_WAIT;
            S_WAIT:   w_next = (r_cnt != 2'd0) ? S_WAIT : (r_ret ? S_EX2 : S_INC_WB);
            S_INC_WB: w_next = S_EX1;
            S_EX1:    w_next = w_adm ? ((ALU_LAT == 0) ? S_EX2 : S_WAIT)
                             : ((r_opcode == OP_XCH) || (r_opcode == OP_CS)) ? S_EX2 : S_DONE;
            S_EX2:    w_next = (r_opcode == OP_XCH) ? S_EX3 : S_DONE;
            S_EX3:    w_next = S_DONE;
`ifdef AGC_SEQ_STEP_EN
            S_HOLD:   w_next = step ? S_FETCH : S_HOLD;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    // The counter and return tag are loaded only on entry to WAIT; r_ret picks INC_WB or EX2 on exit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_RST;
            r_opcode <= 3'd0;
            r_cnt    <= 2'd0;
            r_ret    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH)
                r_opcode <= mem_data[15:13];
            if (w_next == S_WAIT && r_state != S_WAIT) begin
                r_cnt <= LAT_M1;
                r_ret <= (r_state == S_EX1);
            end else if (r_state == S_WAIT)
                r_cnt <= r_cnt - 2'd1;
        end
    end

    // Moore decode; an async reset forces S_RST so every enable drops at once.
    always_comb begin
        alu_op     = ALU_ADD;
        MAddr_MUX  = 2'd0;
        Q_MUX      = 2'd0;
        A_MUX      = 2'd0;
        X_MUX      = 2'd0;
        Z_MUX      = 2'd0;
        Y_MUX      = 2'd0;
        LP_MUX     = 1'b0;
        B_MUX      = 1'b0;
        LP_WE      = 1'b0;
        G_WE       = 1'b0;
        Q_WE       = 1'b0;
        B_WE       = 1'b0;
        A_WE       = 1'b0;
        Y_WE       = 1'b0;
        X_WE       = 1'b0;
        Z_WE       = 1'b0;
        mem_WE     = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                B_WE = 1'b1;
                G_WE = 1'b1;
            end
            S_INC_LD: begin
                X_MUX = 2'd1;
                X_WE  = 1'b1;
                Y_MUX = 2'd2;
                Y_WE  = 1'b1;
            end
            S_WAIT:   alu_op = r_ret ? w_alu : ALU_ADD;
            S_INC_WB: begin
                Z_MUX = 2'd1;
                Z_WE  = 1'b1;
            end
            S_EX1: begin
                case (r_opcode)
                    OP_TC: begin
                        Q_MUX      = 2'd2;
                        Q_WE       = 1'b1;
                        Z_MUX      = 2'd2;
                        Z_WE       = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_CA: begin
                        MAddr_MUX  = 2'd1;
                        A_WE       = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_AD, OP_MASK: begin
                        MAddr_MUX = 2'd1;
                        X_WE      = 1'b1;
                        Y_MUX     = 2'd1;
                        Y_WE      = 1'b1;
                        alu_op    = w_alu;
                    end
                    OP_TS: begin
                        MAddr_MUX  = 2'd1;
                        mem_WE     = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_XCH: begin
                        MAddr_MUX = 2'd1;
                        G_WE      = 1'b1;
                    end
                    OP_CS: begin
                        MAddr_MUX = 2'd1;
                        A_WE      = 1'b1;
                    end
                    default: begin
                        Z_MUX      = 2'd2;
                        Z_WE       = acc_zero;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_EX2: begin
                case (r_opcode)
                    OP_AD, OP_MASK: begin
                        A_MUX      = 2'd1;
                        A_WE       = 1'b1;
                        alu_op     = w_alu;
                        instr_done = 1'b1;
                    end
                    OP_XCH: begin
                        MAddr_MUX = 2'd1;
                        mem_WE    = 1'b1;
                    end
                    default: begin
                        A_MUX      = 2'd2;
                        A_WE       = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_EX3: begin
                A_MUX      = 2'd3;
                A_WE       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
